// File: rtl/psg_bank_ctrl.sv
// psg_bank_ctrl: buffered write sequencer, per-chip filter/mute registers and
// saturating mixer for a bank of SN76489-class PSGs sharing one data bus.
module psg_bank_ctrl #(
  parameter int NUM_CHIPS     = 3,
  parameter int FIFO_DEPTH    = 4,
  parameter int FILT_W        = 2,
  parameter int SMP_W         = 16,
  parameter int GAIN          = 176,
  parameter int READY_TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          psg_cen,
  input  logic                          mix_cen,
  input  logic                          wr_req,
  input  logic [2:0]                    wr_chip,
  input  logic [7:0]                    wr_data,
  output logic                          wr_full,
  input  logic                          filt_wr,
  input  logic [2:0]                    filt_chip,
  input  logic [FILT_W-1:0]             filt_sel,
  input  logic                          filt_mute,
  output logic [NUM_CHIPS*FILT_W-1:0]   filt_sel_o,
  output logic [7:0]                    psg_d,
  output logic [NUM_CHIPS-1:0]          psg_ce_n,
  output logic                          psg_we_n,
  input  logic [NUM_CHIPS-1:0]          psg_ready,
  input  logic [NUM_CHIPS*SMP_W-1:0]    psg_in,
  output logic signed [SMP_W-1:0]       mix_out,
  output logic                          err_ovf,
  output logic                          err_tout,
  output logic [2:0]                    tout_chip
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int TO_W   = $clog2(READY_TIMEOUT + 1);
  localparam int SUM_W  = SMP_W + 3;
  localparam int PROD_W = SUM_W + 11;

  localparam logic signed [PROD_W-1:0] GAIN_S  = PROD_W'(GAIN);
  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((1 << (SMP_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-(1 << (SMP_W - 1)));

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_WAIT_HI,
    S_RELEASE
  } state_t;

  state_t                  state, state_next;
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        count, count_next;
  logic [2:0]              fifo_chip [FIFO_DEPTH];
  logic [7:0]              fifo_data [FIFO_DEPTH];
  logic                    chip_ok, push, pop;
  logic [2:0]              cur_chip;
  logic [TO_W-1:0]         tcnt, tcnt_next;
  logic                    ready_sel, tout_fire;
  logic [NUM_CHIPS-1:0]    mute_r;
  logic signed [SMP_W-1:0] smp;
  logic signed [SUM_W-1:0] sum;
  logic signed [PROD_W-1:0] prod;

  // Writes to chips that do not exist are discarded without flagging.
  assign chip_ok    = int'(wr_chip) < NUM_CHIPS;
  // Full is taken from the registered count, so a push while full is dropped
  // even when a pop happens in the same clk.
  assign push       = wr_req && chip_ok && !wr_full;
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);

  // FIFO pointers, occupancy, registered full flag and sticky overflow flag.
  // NOTE: state registers use nonblocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      wr_full <= 1'b0;
      err_ovf <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count   <= count_next;
      wr_full <= (count_next == CNT_W'(FIFO_DEPTH));
      if (wr_req && chip_ok && wr_full) err_ovf <= 1'b1;
    end
  end

  // FIFO storage, written only by accepted pushes.
  // NOTE: the storage array has no reset; occupancy lives in count, so a
  // stale entry is never read after reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_chip[wr_ptr] <= wr_chip;
      fifo_data[wr_ptr] <= wr_data;
    end
  end

  // READY of the chip currently being written.
  always_comb begin
    ready_sel = 1'b0;
    for (int i = 0; i < NUM_CHIPS; i++)
      if (cur_chip == 3'(i)) ready_sel = psg_ready[i];
  end

  // Handshake next-state logic; only psg_cen ticks advance it.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case can infer a latch.
    state_next = state;
    pop        = 1'b0;
    tcnt_next  = tcnt;
    tout_fire  = 1'b0;
    if (psg_cen) begin
      unique case (state)
        S_IDLE: begin
          if (count != '0) begin
            pop        = 1'b1;
            state_next = S_SETUP;
          end
        end
        S_SETUP: begin
          tcnt_next  = '0;
          state_next = S_STROBE;
        end
        S_STROBE, S_WAIT_HI: begin
          tcnt_next = tcnt + TO_W'(1);
          // A genuine READY transition wins over an abort on the same tick.
          if (state == S_STROBE && !ready_sel) begin
            state_next = S_WAIT_HI;
          end else if (state == S_WAIT_HI && ready_sel) begin
            state_next = S_RELEASE;
          end else if (tcnt_next == TO_W'(READY_TIMEOUT)) begin
            tout_fire  = 1'b1;
            state_next = S_RELEASE;
          end
        end
        S_RELEASE: state_next = S_IDLE;
        default:   state_next = S_IDLE;
      endcase
    end
  end

  // Handshake state, latched chip/data, timeout counter and timeout flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      tcnt      <= '0;
      cur_chip  <= '0;
      psg_d     <= '0;
      err_tout  <= 1'b0;
      tout_chip <= '0;
    end else begin
      state <= state_next;
      tcnt  <= tcnt_next;
      if (pop) begin
        cur_chip <= fifo_chip[rd_ptr];
        psg_d    <= fifo_data[rd_ptr];
      end
      if (tout_fire) begin
        err_tout  <= 1'b1;
        tout_chip <= cur_chip;
      end
    end
  end

  // Strobes decoded from the state register; reset forces IDLE, which
  // releases CE/WE without waiting for a clock edge.
  always_comb begin
    psg_ce_n = '1;
    psg_we_n = 1'b1;
    if (state inside {S_SETUP, S_STROBE, S_WAIT_HI}) begin
      for (int i = 0; i < NUM_CHIPS; i++)
        if (cur_chip == 3'(i)) psg_ce_n[i] = 1'b0;
    end
    if (state inside {S_STROBE, S_WAIT_HI}) psg_we_n = 1'b0;
  end

  // Per-chip filter select and mute; out-of-range chip indices match nothing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_sel_o <= '0;
      mute_r     <= '0;
    end else if (filt_wr) begin
      for (int i = 0; i < NUM_CHIPS; i++) begin
        if (filt_chip == 3'(i)) begin
          filt_sel_o[i*FILT_W +: FILT_W] <= filt_sel;
          mute_r[i]                      <= filt_mute;
        end
      end
    end
  end

  // Sum of unmuted samples with three guard bits, scaled by the fixed gain.
  always_comb begin
    smp = '0;
    sum = '0;
    for (int i = 0; i < NUM_CHIPS; i++) begin
      smp = psg_in[i*SMP_W +: SMP_W];
      if (!mute_r[i]) sum = sum + SUM_W'(smp);
    end
    prod = PROD_W'(sum) * GAIN_S;
  end

  // Saturating output register, held between mix_cen pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mix_out <= '0;
    end else if (mix_cen) begin
      if (prod > SAT_MAX)      mix_out <= SMP_W'(SAT_MAX);
      else if (prod < SAT_MIN) mix_out <= SMP_W'(SAT_MIN);
      else                     mix_out <= SMP_W'(prod);
    end
  end

endmodule
